// File: rtl/fifo_fsize_sync_if.sv
// ---------------------------------------------------------------------------
// fifo_fsize_sync_if
//
// Purpose : groups the producer/consumer handshake and the status outputs of
//           fifo_fsize_sync into one bundle. Clock and resets stay plain ports
//           on the FIFO itself.
//
// Parameters
//   DW     data width in bits
//   DEPTH  number of FIFO entries (only used to size cnt)
//
// Signals
//   enq      write request                 (user -> FIFO)
//   deq      read request                  (user -> FIFO)
//   din      write data                    (user -> FIFO)
//   dot      registered read data          (FIFO -> user)
//   dot_vld  one-cycle pulse, dot updated  (FIFO -> user)
//   full     cnt == DEPTH                  (FIFO -> user)
//   empty    cnt == 0                      (FIFO -> user)
//   afull    cnt >= AFULL_TH               (FIFO -> user)
//   cnt      current occupancy             (FIFO -> user)
//   ovf      sticky overflow error         (FIFO -> user)
//   udf      sticky underflow error        (FIFO -> user)
//
// Modports
//   master : the side that issues enq/deq (producer + consumer)
//   slave  : the FIFO
// ---------------------------------------------------------------------------
interface fifo_fsize_sync_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4608
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          enq;
  logic          deq;
  logic [DW-1:0] din;
  logic [DW-1:0] dot;
  logic          dot_vld;
  logic          full;
  logic          empty;
  logic          afull;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          udf;

  modport master (
    output enq, deq, din,
    input  dot, dot_vld, full, empty, afull, cnt, ovf, udf
  );

  modport slave (
    input  enq, deq, din,
    output dot, dot_vld, full, empty, afull, cnt, ovf, udf
  );
endinterface

// File: rtl/fifo_fsize_sync.sv
// ---------------------------------------------------------------------------
// fifo_fsize_sync
//
// Purpose : single-clock FIFO of arbitrary (non power-of-two) depth with an
//           occupancy count, full/empty/almost-full flags and registered read
//           data. Pointers wrap at an explicit bound of DEPTH-1.
//
// Parameters
//   DW        data width
//   DEPTH     number of entries, any integer >= 2
//   AFULL_TH  afull asserts when cnt >= AFULL_TH (1..DEPTH)
//
// Ports
//   CLK    clock, all logic on posedge
//   RST_X  asynchronous active-low reset
//   SRST   synchronous clear, active high, priority over enq/deq
//   bus    fifo_fsize_sync_if.slave (enq/deq/din in; dot/dot_vld/full/empty/
//          afull/cnt/ovf/udf out)
//
// Optional feature
//   FIFO_FSIZE_ERRFLAG_EN : when defined, ovf sets on any rejected enq and udf
//                           on any rejected deq, both sticky until reset.
//                           When undefined both outputs are tied low.
// ---------------------------------------------------------------------------
module fifo_fsize_sync #(
  parameter int DW       = 32,
  parameter int DEPTH    = 4608,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              SRST,
  fifo_fsize_sync_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_ADR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] ADR_ONE   = AW'(1);

  // Storage: no reset, so it maps onto block RAM.
  logic [DW-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wadr;
  logic [AW-1:0] r_radr;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dot;
  logic          r_dot_vld;

  logic          w_full;
  logic          w_empty;
  logic          w_afull;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW-1:0] w_wadr_next;
  logic [AW-1:0] w_radr_next;
  logic [CW-1:0] w_cnt_next;

  // Status is a pure decode of the count register, so no request input has a
  // combinational path to any output.
  assign w_full  = (r_cnt == CNT_MAX);
  assign w_empty = (r_cnt == '0);
  assign w_afull = (r_cnt >= CNT_AFULL);

  // A write at full is still accepted when a read frees a slot in the same
  // cycle. DEPTH >= 2 means full implies non-empty, so that read is always
  // accepted too.
  assign w_wr_ok = bus.enq & (~w_full | bus.deq);
  // No bypass: at empty the read is rejected even when a write arrives.
  assign w_rd_ok = bus.deq & ~w_empty;

  // Explicit wrap bound; pointer values >= DEPTH are never produced.
  assign w_wadr_next = (r_wadr == LAST_ADR) ? '0 : r_wadr + ADR_ONE;
  assign w_radr_next = (r_radr == LAST_ADR) ? '0 : r_radr + ADR_ONE;

  always_comb begin
    w_cnt_next = r_cnt;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_cnt_next = r_cnt + CNT_ONE;
      2'b01:   w_cnt_next = r_cnt - CNT_ONE;
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Memory write port. SRST wins over a simultaneous enq.
  always_ff @(posedge CLK) begin
    if (w_wr_ok && !SRST) begin
      r_mem[r_wadr] <= bus.din;
    end
  end

  // Pointers, count and registered read data.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_wadr    <= '0;
      r_radr    <= '0;
      r_cnt     <= '0;
      r_dot     <= '0;
      r_dot_vld <= 1'b0;
    end else if (SRST) begin
      r_wadr    <= '0;
      r_radr    <= '0;
      r_cnt     <= '0;
      r_dot     <= '0;
      r_dot_vld <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_dot_vld <= w_rd_ok;
      if (w_wr_ok) begin
        r_wadr <= w_wadr_next;
      end
      if (w_rd_ok) begin
        r_radr <= w_radr_next;
        r_dot  <= r_mem[r_radr];
      end
    end
  end

`ifdef FIFO_FSIZE_ERRFLAG_EN
  logic r_ovf;
  logic r_udf;
  logic w_enq_rej;
  logic w_deq_rej;

  assign w_enq_rej = bus.enq & ~w_wr_ok;
  assign w_deq_rej = bus.deq & ~w_rd_ok;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (SRST) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_enq_rej) r_ovf <= 1'b1;
      if (w_deq_rej) r_udf <= 1'b1;
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.dot     = r_dot;
  assign bus.dot_vld = r_dot_vld;
  assign bus.full    = w_full;
  assign bus.empty   = w_empty;
  assign bus.afull   = w_afull;
  assign bus.cnt     = r_cnt;

endmodule

// File: tb/tb_fifo_fsize_sync.sv
// ---------------------------------------------------------------------------
// tb_fifo_fsize_sync : directed bench for fifo_fsize_sync at DEPTH=5,
// AFULL_TH=4. A table of single-cycle vectors covers fill, overflow attempt,
// drain, underflow attempt, pass-through at full/empty and SRST; hand-written
// sequences cover pointer wrap at steady occupancy and an asynchronous reset
// pulse between clock edges.
// ---------------------------------------------------------------------------
module tb_fifo_fsize_sync;

  localparam int DW    = 32;
  localparam int DEPTH = 5;
  localparam int ATH   = 4;

`ifdef FIFO_FSIZE_ERRFLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLK;
  logic RST_X;
  logic SRST;

  fifo_fsize_sync_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  fifo_fsize_sync #(.DW(DW), .DEPTH(DEPTH), .AFULL_TH(ATH)) dut (
    .CLK  (CLK),
    .RST_X(RST_X),
    .SRST (SRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          enq;
    bit          deq;
    bit          srst;
    logic [31:0] din;
    int          cnt;
    bit          full;
    bit          empty;
    bit          afull;
    logic [31:0] dot;
    bit          vld;
    bit          ovf;
    bit          udf;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input int cnt, input bit full, input bit empty,
                         input bit afull, input logic [31:0] dot, input bit vld,
                         input bit ovf, input bit udf);
    chk({tag, ".cnt"},     32'(bus.cnt),   32'(cnt));
    chk({tag, ".full"},    32'(bus.full),  32'(full));
    chk({tag, ".empty"},   32'(bus.empty), 32'(empty));
    chk({tag, ".afull"},   32'(bus.afull), 32'(afull));
    chk({tag, ".dot"},     bus.dot,        dot);
    chk({tag, ".dot_vld"}, 32'(bus.dot_vld), 32'(vld));
    chk({tag, ".ovf"},     32'(bus.ovf),   32'(ovf & ERR_EN));
    chk({tag, ".udf"},     32'(bus.udf),   32'(udf & ERR_EN));
  endtask

  // Drive at negedge, let one posedge happen, then sample 1 ns later.
  task automatic step(input bit enq, input bit deq, input bit srst, input logic [31:0] din);
    @(negedge CLK);
    bus.enq = enq;
    bus.deq = deq;
    bus.din = din;
    SRST    = srst;
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input bit enq, input bit deq, input bit srst, input logic [31:0] din,
                     input int cnt, input logic [31:0] dot, input bit vld,
                     input bit ovf, input bit udf);
    vec_t v;
    v.enq = enq; v.deq = deq; v.srst = srst; v.din = din;
    v.cnt = cnt;
    v.full  = (cnt == DEPTH);
    v.empty = (cnt == 0);
    v.afull = (cnt >= ATH);
    v.dot = dot; v.vld = vld; v.ovf = ovf; v.udf = udf;
    tbl.push_back(v);
  endtask

  logic [31:0] model_q[$];
  logic [31:0] exp_d;

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < 5; i++) add(1, 0, 0, 32'h10 + i, i + 1, 0, 0, 0, 0);
    add(1, 0, 0, 32'hFF, 5, 0, 0, 1, 0);                         // enq at full rejected
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 4 - i, 32'h10 + i, 1, 1, 0);
    add(0, 1, 0, 0, 0, 32'h14, 0, 1, 1);                         // deq at empty rejected
    add(1, 1, 0, 32'h20, 1, 32'h14, 0, 1, 1);                    // enq+deq at empty
    for (int i = 0; i < 4; i++) add(1, 0, 0, 32'h21 + i, i + 2, 32'h14, 0, 1, 1);
    add(1, 1, 0, 32'h25, 5, 32'h20, 1, 1, 1);                    // enq+deq at full
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 4 - i, 32'h21 + i, 1, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 32'h30 + i, i + 1, 32'h25, 0, 1, 1);
    add(1, 0, 1, 32'h33, 0, 0, 0, 0, 0);                         // SRST beats enq at cnt=3

    // ---------------- reset ----------------
    RST_X   = 1'b0;
    SRST    = 1'b0;
    bus.enq = 1'b0;
    bus.deq = 1'b0;
    bus.din = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST_X = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].enq, tbl[k].deq, tbl[k].srst, tbl[k].din);
      $display("vec %0d: enq=%0b deq=%0b srst=%0b din=%0h -> cnt=%0d dot=%0h vld=%0b",
               k, tbl[k].enq, tbl[k].deq, tbl[k].srst, tbl[k].din,
               bus.cnt, bus.dot, bus.dot_vld);
      chk_all($sformatf("vec%0d", k), tbl[k].cnt, tbl[k].full, tbl[k].empty, tbl[k].afull,
              tbl[k].dot, tbl[k].vld, tbl[k].ovf, tbl[k].udf);
    end

    // ---------------- wrap-around at occupancy 2 ----------------
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 32'h40 + i);
      model_q.push_back(32'h40 + i);
      $display("wrap prefill %0d: din=%0h cnt=%0d", i, 32'h40 + i, bus.cnt);
      chk($sformatf("prefill%0d.cnt", i), 32'(bus.cnt), 32'(i + 1));
    end
    for (int i = 0; i < 13; i++) begin
      step(1, 1, 0, 32'h42 + i);
      model_q.push_back(32'h42 + i);
      exp_d = model_q.pop_front();
      $display("wrap %0d: din=%0h dot=%0h cnt=%0d", i, 32'h42 + i, bus.dot, bus.cnt);
      chk($sformatf("wrap%0d.dot", i),     bus.dot,          exp_d);
      chk($sformatf("wrap%0d.dot_vld", i), 32'(bus.dot_vld), 32'd1);
      chk($sformatf("wrap%0d.cnt", i),     32'(bus.cnt),     32'd2);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0);
      exp_d = model_q.pop_front();
      $display("wrap drain %0d: dot=%0h cnt=%0d", i, bus.dot, bus.cnt);
      chk($sformatf("wdrain%0d.dot", i), bus.dot,      exp_d);
      chk($sformatf("wdrain%0d.cnt", i), 32'(bus.cnt), 32'(1 - i));
    end
    chk("wrap.empty", 32'(bus.empty), 32'd1);

    // ---------------- asynchronous reset between edges ----------------
    step(1, 0, 0, 32'h50);
    step(0, 1, 0, 0);
    $display("pre-async: dot=%0h vld=%0b cnt=%0d", bus.dot, bus.dot_vld, bus.cnt);
    chk("preasync.dot", bus.dot, 32'h50);
    chk("preasync.vld", 32'(bus.dot_vld), 32'd1);
    step(1, 0, 0, 32'h51);                      // leave one entry, dot still 0x50
    bus.enq = 1'b0;
    #2;
    RST_X = 1'b0;                               // mid high phase, no edge
    #1;
    $display("async reset: dot=%0h vld=%0b cnt=%0d empty=%0b", bus.dot, bus.dot_vld,
             bus.cnt, bus.empty);
    chk_all("async", 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    RST_X = 1'b1;
    step(0, 0, 0, 0);
    chk_all("postasync", 0, 0, 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fifo_fsize_sync.md
# fifo_fsize_sync

Single-clock FIFO of arbitrary, non-power-of-two depth with occupancy count, full/empty/almost-full flags and registered read data. Successor to the two-memory fixed-size FIFO: the depth is any integer, the pointer wraps at an explicit bound, and status is exposed to the producer and the consumer. It sits between a line-rate producer and a bursty consumer in one clock domain.

## Interface
- DW, 32, data width in bits
- DEPTH, 4608, number of entries; any integer ≥ 2
- AFULL_TH, DEPTH-4, afull asserts when cnt ≥ AFULL_TH; legal range 1..DEPTH
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

- CLK  in  1  clock; all logic on posedge
- RST_X  in  1  asynchronous active-low reset
- SRST  in  1  synchronous clear, active high
- enq  in  1  write request
- deq  in  1  read request
- din  in  DW  write data
- dot  out  DW  read data, registered
- dot_vld  out  1  one-cycle pulse: dot updated this cycle
- full  out  1  cnt == DEPTH
- empty  out  1  cnt == 0
- afull  out  1  cnt ≥ AFULL_TH
- cnt  out  CW  current occupancy
- ovf  out  1  sticky overflow error (macro-dependent)
- udf  out  1  sticky underflow error (macro-dependent)

## Operation
- Storage: one DEPTH×DW array; write pointer wadr and read pointer radr, both AW bits.
- Accepted write: enq & ~full, or enq & full & deq (pass-through at full). Writes din at wadr.
- Accepted read: deq & ~empty. Reads mem[radr] into dot.
- Empty + enq + deq: write accepted, read rejected; no bypass of din to dot.
- Pointer advance: if ptr == DEPTH-1 then 0, else ptr+1. Values ≥ DEPTH never occur.
- cnt: +1 on write only, −1 on read only, unchanged on both or neither. Never exceeds DEPTH, never underflows.
- Rejected enq (full, no deq) and rejected deq (empty): no state change except error flags.
- full, empty, afull decoded from the cnt register only; no combinational path from enq/deq/din to any output.
- dot holds its last value when no read is accepted.
- SRST: same effect as RST_X on all state; priority over enq/deq in that cycle. Memory contents are not cleared.

## Timing
- Reset values (RST_X low, or SRST high at edge): dot=0, dot_vld=0, cnt=0, empty=1, full=0, afull=0, ovf=0, udf=0, wadr=radr=0.
- Write-to-status latency: cnt/flags reflect an accepted write on the edge that accepts it (visible the following cycle).
- Read latency 1: deq accepted at edge N → dot = entry and dot_vld=1 after edge N; dot_vld=0 after edge N+1 unless another read is accepted.
- Write-to-read: an entry written at edge N is readable by a deq presented in the cycle after edge N (empty already deasserted).
- Full throughput: one write and one read per cycle sustained at any occupancy 1..DEPTH.
- RST_X asserted mid-burst: all outputs go to reset values immediately, without a clock edge.

## Configuration
- FIFO_FSIZE_ERRFLAG_EN defined: ovf sets on any rejected enq, udf sets on any rejected deq; both sticky until RST_X or SRST.
- Not defined: ovf and udf tied to 0; rejected requests silently ignored; no error logic synthesised.

## Test plan
- DEPTH=5, AFULL_TH=4: reset, write 5 words 0x10..0x14 → cnt 1..5, afull at cnt=4, full at cnt=5, empty=0 from first write.
- Continue from full: enq alone with din=0xFF → cnt stays 5, data unchanged; with FIFO_FSIZE_ERRFLAG_EN ovf=1 and stays 1.
- Drain 5 reads → dot 0x10..0x14 each one cycle after deq, dot_vld pulses 5 times, empty=1 at end; 6th deq → dot holds 0x14, dot_vld=0, udf=1 (macro on).
- Wrap-around: DEPTH=5, 13 writes interleaved with 13 reads at occupancy 2 → output order matches input exactly across pointer wrap 4→0; cnt constant at 2 during simultaneous enq+deq.
- Simultaneous enq+deq at full (cnt=5) → both accepted, cnt stays 5, full stays 1; at empty → only the write is accepted, cnt=1, dot_vld=0.
- SRST at cnt=3 with enq asserted → next cycle cnt=0, empty=1, dot=0, ovf/udf cleared, enq ignored; asynchronous RST_X pulse between edges → outputs reset without a clock.
